// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pipeline_hazard_ctrl_if                                    |
// | Brief   : Pipeline-status inputs and stall/flush controls bundle.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  ex_branch_taken;
  logic                  mem_req;
  logic                  mem_ready;
  logic                  halt_req;
  logic                  resume_req;

  logic                  stall_pc;
  logic                  stall_if_id;
  logic                  stall_id_ex;
  logic                  stall_ex_mem;
  logic                  flush_if_id;
  logic                  flush_id_ex;
  logic                  flush_mem_wb;
  logic                  halted;
  logic                  fault;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready, halt_req, resume_req,
    input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
           flush_id_ex, flush_mem_wb, halted, fault, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready, halt_req, resume_req,
    output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
           flush_id_ex, flush_mem_wb, halted, fault, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pipeline_hazard_ctrl                                       |
// | Brief   : Stall/flush controller with halt drain, mem-timeout trap   |
// |           and saturating perf counters.                              |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int MEM_TIMEOUT  = 255,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.slave  bus
);

  localparam int c_WAIT_W  = $clog2(MEM_TIMEOUT);
  localparam int c_DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [c_WAIT_W-1:0]  c_WAIT_LAST  = c_WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [c_WAIT_W-1:0]  c_WAIT_ONE   = c_WAIT_W'(1);
  localparam logic [c_DRAIN_W-1:0] c_DRAIN_INIT = c_DRAIN_W'(DRAIN_CYCLES);
  localparam logic [c_DRAIN_W-1:0] c_DRAIN_ONE  = c_DRAIN_W'(1);
  localparam logic [CNT_W-1:0]     c_CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] c_ST_RUN    = 2'd0;
  localparam logic [1:0] c_ST_DRAIN  = 2'd1;
  localparam logic [1:0] c_ST_HALTED = 2'd2;
  localparam logic [1:0] c_ST_FAULT  = 2'd3;

  logic [1:0]           r_state;
  logic [c_WAIT_W-1:0]  r_wait_cnt;
  logic [c_DRAIN_W-1:0] r_drain_cnt;
  logic [CNT_W-1:0]     r_stall_cnt;
  logic [CNT_W-1:0]     r_flush_cnt;

  logic [REG_ADDR_W-1:0] w_ex_rd;
  logic w_mw, w_lu, w_br;
  logic w_case1, w_case2, w_case3;
  logic w_active;
  logic w_stall_pc, w_stall_if_id, w_stall_id_ex, w_stall_ex_mem;
  logic w_flush_if_id, w_flush_id_ex, w_flush_mem_wb;

  assign w_ex_rd = bus.ex_rd;
  assign w_mw    = bus.mem_req && !bus.mem_ready;
  assign w_lu    = bus.ex_mem_read && (w_ex_rd != '0) &&
                   ((bus.id_rs1_used && (bus.id_rs1 == w_ex_rd)) ||
                    (bus.id_rs2_used && (bus.id_rs2 == w_ex_rd)));
  assign w_br    = bus.ex_branch_taken;

  // Priority: mem wait beats branch beats load-use
  assign w_case1  = w_mw;
  assign w_case2  = !w_mw && w_br;
  assign w_case3  = !w_mw && !w_br && w_lu;
  assign w_active = (r_state == c_ST_RUN) || (r_state == c_ST_DRAIN);

  always_comb begin
    w_stall_pc     = 1'b0;
    w_stall_if_id  = 1'b0;
    w_stall_id_ex  = 1'b0;
    w_stall_ex_mem = 1'b0;
    w_flush_if_id  = 1'b0;
    w_flush_id_ex  = 1'b0;
    w_flush_mem_wb = 1'b0;
    case (r_state)
      c_ST_RUN, c_ST_DRAIN: begin
        w_stall_pc     = w_case1 || w_case3;
        w_stall_if_id  = w_case1 || w_case3;
        w_stall_id_ex  = w_case1;
        w_stall_ex_mem = w_case1;
        w_flush_mem_wb = w_case1;
        w_flush_if_id  = w_case2;
        w_flush_id_ex  = w_case2 || w_case3;
        if (r_state == c_ST_DRAIN) begin
          // Draining: keep the PC frozen and squash fetches unless IF/ID is held
          w_stall_pc    = !w_case2;
          w_flush_if_id = !(w_case1 || w_case3);
        end
      end
      c_ST_HALTED: begin
        w_stall_pc    = 1'b1;
        w_flush_if_id = 1'b1;
      end
      default: begin
        w_stall_pc     = 1'b1;
        w_stall_if_id  = 1'b1;
        w_stall_id_ex  = 1'b1;
        w_stall_ex_mem = 1'b1;
        w_flush_mem_wb = 1'b1;
      end
    endcase
  end

  assign bus.stall_pc     = w_stall_pc     && rst_n;
  assign bus.stall_if_id  = w_stall_if_id  && rst_n;
  assign bus.stall_id_ex  = w_stall_id_ex  && rst_n;
  assign bus.stall_ex_mem = w_stall_ex_mem && rst_n;
  assign bus.flush_if_id  = w_flush_if_id  && rst_n;
  assign bus.flush_id_ex  = w_flush_id_ex  && rst_n;
  assign bus.flush_mem_wb = w_flush_mem_wb && rst_n;
  assign bus.halted       = (r_state == c_ST_HALTED);
  assign bus.fault        = (r_state == c_ST_FAULT);
  assign bus.stall_cnt    = r_stall_cnt;
  assign bus.flush_cnt    = r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_ST_RUN;
      r_wait_cnt  <= '0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        c_ST_RUN, c_ST_DRAIN: begin
          if (w_mw) begin
            if (r_wait_cnt == c_WAIT_LAST) begin
              r_state <= c_ST_FAULT;
            end else begin
              r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
            end
          end else begin
            r_wait_cnt <= '0;
            if ((r_state == c_ST_RUN) && bus.halt_req) begin
              r_state     <= c_ST_DRAIN;
              r_drain_cnt <= c_DRAIN_INIT;
            end else if ((r_state == c_ST_DRAIN) && !w_case3) begin
              if (r_drain_cnt == c_DRAIN_ONE) begin
                r_state <= c_ST_HALTED;
              end else begin
                r_drain_cnt <= r_drain_cnt - c_DRAIN_ONE;
              end
            end
          end
        end
        c_ST_HALTED: begin
          r_wait_cnt <= '0;
          if (bus.resume_req) begin
            r_state <= c_ST_RUN;
          end
        end
        default: begin
          r_state <= c_ST_FAULT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (w_active) begin
      if (w_stall_pc && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      end
      if (w_case2 && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_pipeline_hazard_ctrl                                    |
// | Brief   : Directed self-checking bench for pipeline_hazard_ctrl.     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

  // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex, flush_mem_wb}
  localparam logic [6:0] c_NONE  = 7'b0000000;
  localparam logic [6:0] c_LU    = 7'b1100010;
  localparam logic [6:0] c_BR    = 7'b0000110;
  localparam logic [6:0] c_MW    = 7'b1111001;
  localparam logic [6:0] c_DRAIN = 7'b1000100;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [6:0] ctl;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) bus ();

  pipeline_hazard_ctrl #(
    .REG_ADDR_W  (5),
    .MEM_TIMEOUT (8),
    .DRAIN_CYCLES(4),
    .CNT_W       (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign ctl = {bus.stall_pc, bus.stall_if_id, bus.stall_id_ex, bus.stall_ex_mem,
                bus.flush_if_id, bus.flush_id_ex, bus.flush_mem_wb};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0;
    bus.ex_rd = '0; bus.ex_mem_read = 1'b0; bus.ex_branch_taken = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0; bus.halt_req = 1'b0; bus.resume_req = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.mem_req = 1'b1;
    bus.ex_branch_taken = 1'b1;
    #2;
    checks++;
    if (ctl !== c_NONE) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctl, c_NONE); end
    checks++;
    if (bus.halted !== 1'b0 || bus.fault !== 1'b0) begin
      errors++; $display("FAIL reset_state: halted=%b fault=%b want 0 0", bus.halted, bus.fault);
    end
    tick();
    checks++;
    if (bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt: stall=%0d flush=%0d want 0 0", bus.stall_cnt, bus.flush_cnt);
    end
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    apply_reset();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_rs1_used = 1'b1;
    #2;
    checks++;
    if (ctl !== c_LU) begin errors++; $display("FAIL lu_rs1: got %b want %b", ctl, c_LU); end
    bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0;
    #1;
    checks++;
    if (ctl !== c_NONE) begin errors++; $display("FAIL lu_x0: got %b want %b", ctl, c_NONE); end
    bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9; bus.id_rs1_used = 1'b0;
    bus.id_rs2 = 5'd3;
    #1;
    checks++;
    if (ctl !== c_NONE) begin errors++; $display("FAIL lu_unused: got %b want %b", ctl, c_NONE); end
    tick();
    bus.id_rs2 = 5'd9; bus.id_rs2_used = 1'b1;
    #2;
    checks++;
    if (ctl !== c_LU) begin errors++; $display("FAIL lu_rs2: got %b want %b", ctl, c_LU); end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus.stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", bus.stall_cnt); end
  endtask

  task automatic test_branch_priority();
    apply_reset();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7; bus.id_rs1_used = 1'b1;
    bus.ex_branch_taken = 1'b1;
    #2;
    checks++;
    if (ctl !== c_BR) begin errors++; $display("FAIL br_over_lu: got %b want %b", ctl, c_BR); end
    checks++;
    if (bus.flush_cnt !== 32'd0) begin errors++; $display("FAIL br_cnt_pre: got %0d want 0", bus.flush_cnt); end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus.flush_cnt !== 32'd1 || bus.stall_cnt !== 32'd0) begin
      errors++; $display("FAIL br_cnt: flush=%0d stall=%0d want 1 0", bus.flush_cnt, bus.stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    apply_reset();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0; bus.ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (ctl !== c_MW) begin errors++; $display("FAIL mw_cycle%0d: got %b want %b", i, ctl, c_MW); end
      tick();
    end
    bus.mem_ready = 1'b1;
    #2;
    checks++;
    if (ctl !== c_BR) begin errors++; $display("FAIL mw_release: got %b want %b", ctl, c_BR); end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus.stall_cnt !== 32'd3 || bus.flush_cnt !== 32'd1) begin
      errors++; $display("FAIL mw_cnt: stall=%0d flush=%0d want 3 1", bus.stall_cnt, bus.flush_cnt);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      #2;
      checks++;
      if (bus.fault !== 1'b0 || ctl !== c_MW) begin
        errors++; $display("FAIL to_wait%0d: fault=%b ctl=%b want 0 %b", i, bus.fault, ctl, c_MW);
      end
      tick();
    end
    #1;
    checks++;
    if (bus.fault !== 1'b1) begin errors++; $display("FAIL to_fault: got %b want 1", bus.fault); end
    bus.mem_ready = 1'b1; bus.mem_req = 1'b0; bus.ex_branch_taken = 1'b1; bus.halt_req = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.fault !== 1'b1 || ctl !== c_MW) begin
      errors++; $display("FAIL to_hold: fault=%b ctl=%b want 1 %b", bus.fault, ctl, c_MW);
    end
    checks++;
    if (bus.stall_cnt !== 32'd8 || bus.flush_cnt !== 32'd0) begin
      errors++; $display("FAIL to_cnt: stall=%0d flush=%0d want 8 0", bus.stall_cnt, bus.flush_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.fault !== 1'b0 || ctl !== c_NONE) begin
      errors++; $display("FAIL to_reset: fault=%b ctl=%b want 0 %b", bus.fault, ctl, c_NONE);
    end
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_halt();
    apply_reset();
    bus.halt_req = 1'b1;
    #2;
    checks++;
    if (ctl !== c_NONE) begin errors++; $display("FAIL halt_req_cycle: got %b want %b", ctl, c_NONE); end
    tick();
    bus.halt_req = 1'b0;
    #2;
    checks++;
    if (ctl !== c_DRAIN || bus.halted !== 1'b0) begin
      errors++; $display("FAIL drain1: ctl=%b halted=%b want %b 0", ctl, bus.halted, c_DRAIN);
    end
    tick();
    bus.ex_branch_taken = 1'b1;
    #2;
    checks++;
    if (ctl !== c_BR) begin errors++; $display("FAIL drain2_br: got %b want %b", ctl, c_BR); end
    tick();
    bus.ex_branch_taken = 1'b0;
    #2;
    checks++;
    if (ctl !== c_DRAIN) begin errors++; $display("FAIL drain3: got %b want %b", ctl, c_DRAIN); end
    tick();
    #2;
    checks++;
    if (ctl !== c_DRAIN || bus.halted !== 1'b0) begin
      errors++; $display("FAIL drain4: ctl=%b halted=%b want %b 0", ctl, bus.halted, c_DRAIN);
    end
    tick();
    #2;
    checks++;
    if (bus.halted !== 1'b1 || ctl !== c_DRAIN) begin
      errors++; $display("FAIL halted: halted=%b ctl=%b want 1 %b", bus.halted, ctl, c_DRAIN);
    end
    bus.resume_req = 1'b1;
    tick();
    bus.resume_req = 1'b0;
    #2;
    checks++;
    if (bus.halted !== 1'b0 || ctl !== c_NONE) begin
      errors++; $display("FAIL resume: halted=%b ctl=%b want 0 %b", bus.halted, ctl, c_NONE);
    end
    checks++;
    if (bus.stall_cnt !== 32'd3 || bus.flush_cnt !== 32'd1) begin
      errors++; $display("FAIL halt_cnt: stall=%0d flush=%0d want 3 1", bus.stall_cnt, bus.flush_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    #2;
    checks++;
    if (ctl !== c_MW) begin errors++; $display("FAIL drain_mw: got %b want %b", ctl, c_MW); end
    tick();
    checks++;
    if (bus.stall_cnt !== 32'd1) begin errors++; $display("FAIL drain_mw_cnt: got %0d want 1", bus.stall_cnt); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctl !== c_NONE || bus.halted !== 1'b0 || bus.fault !== 1'b0) begin
      errors++; $display("FAIL mid_reset: ctl=%b halted=%b fault=%b want %b 0 0", ctl, bus.halted, bus.fault, c_NONE);
    end
    checks++;
    if (bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0) begin
      errors++; $display("FAIL mid_reset_cnt: stall=%0d flush=%0d want 0 0", bus.stall_cnt, bus.flush_cnt);
    end
    tick();
    idle_inputs();
    rst_n = 1'b1;
    tick();
    tick();
    #2;
    checks++;
    if (ctl !== c_NONE || bus.stall_cnt !== 32'd0) begin
      errors++; $display("FAIL post_reset_run: ctl=%b stall=%0d want %b 0", ctl, bus.stall_cnt, c_NONE);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete within time budget");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_branch_priority();
    test_mem_wait();
    test_timeout();
    test_halt();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
